// File: rtl/gamma_inverse_pwl.sv
// Inverse-gamma linearizer: 16-segment PWL curve from a shared 17-entry breakpoint table, 3 planes.
// Optional per-pixel bypass port when GAMMA_INV_BYPASS_EN is defined.
module gamma_inverse_pwl #(
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inpvalid,
    input  logic [DATA_W-1:0] din0,
    input  logic [DATA_W-1:0] din1,
    input  logic [DATA_W-1:0] din2,
    input  logic              wr_en,
    input  logic [4:0]        wr_addr,
    input  logic [12:0]       wr_data,
`ifdef GAMMA_INV_BYPASS_EN
    input  logic              bypass,
`endif
    output logic              outvalid,
    output logic [DATA_W-1:0] dout0,
    output logic [DATA_W-1:0] dout1,
    output logic [DATA_W-1:0] dout2
);

    logic [12:0]       bp [0:16];
    logic [DATA_W-1:0] din_a [3];
    logic              byp_in;

    logic              vld_p0, vld_p1, vld_p2;
    logic              byp_p0, byp_p1;
    logic [DATA_W-1:0] din_p0 [3];
    logic [12:0]       base_p0 [3];
    logic [12:0]       next_p0 [3];
    logic [DATA_W-1:0] din_p1 [3];
    logic [12:0]       base_p1 [3];
    logic signed [21:0] prod_p1 [3];
    logic [DATA_W-1:0] dout_p2 [3];

    logic signed [13:0] d_c [3];
    logic signed [21:0] prod_c [3];

    assign din_a[0] = din0;
    assign din_a[1] = din1;
    assign din_a[2] = din2;

`ifdef GAMMA_INV_BYPASS_EN
    assign byp_in = bypass;
`else
    assign byp_in = 1'b0;
`endif

    function automatic logic [DATA_W-1:0] round_clamp(input logic signed [21:0] p,
                                                      input logic [12:0] base);
        logic signed [21:0] r;
        logic signed [15:0] y;
        logic [DATA_W-1:0]  res;
        r = (p + 22'sd128) >>> 8;
        y = 16'(r) + signed'({3'b000, base});
        if (y < 16'sd0)
            res = '0;
        else if (y > 16'sd4095)
            res = 12'd4095;
        else
            res = y[11:0];
        return res;
    endfunction

    // Control, table and output register: asynchronous reset restores identity table.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            for (int k = 0; k < 17; k++) bp[k] <= 13'(256 * k);
            for (int p = 0; p < 3; p++) dout_p2[p] <= '0;
        end else begin
            vld_p0 <= inpvalid;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
            if (wr_en && (wr_addr <= 5'd16)) bp[wr_addr] <= wr_data;
            // S3: round, clamp, register output
            if (vld_p1) begin
                for (int p = 0; p < 3; p++)
                    dout_p2[p] <= byp_p1 ? din_p1[p] : round_clamp(prod_p1[p], base_p1[p]);
            end
        end
    end

    always_comb begin
        for (int p = 0; p < 3; p++) begin
            d_c[p]    = signed'({1'b0, next_p0[p]}) - signed'({1'b0, base_p0[p]});
            prod_c[p] = signed'({{8{d_c[p][13]}}, d_c[p]}) * signed'({14'b0, din_p0[p][7:0]});
        end
    end

    // S1 captures table entries before any same-edge write lands; S2 registers the product.
    always_ff @(posedge clk) begin
        if (inpvalid) begin
            byp_p0 <= byp_in;
            for (int p = 0; p < 3; p++) begin
                din_p0[p]  <= din_a[p];
                base_p0[p] <= bp[{1'b0, din_a[p][11:8]}];
                next_p0[p] <= bp[{1'b0, din_a[p][11:8]} + 5'd1];
            end
        end
        if (vld_p0) begin
            byp_p1 <= byp_p0;
            for (int p = 0; p < 3; p++) begin
                din_p1[p]  <= din_p0[p];
                base_p1[p] <= base_p0[p];
                prod_p1[p] <= prod_c[p];
            end
        end
    end

    assign outvalid = vld_p2;
    assign dout0    = dout_p2[0];
    assign dout1    = dout_p2[1];
    assign dout2    = dout_p2[2];

endmodule

// File: tb/tb_gamma_inverse_pwl.sv
// Self-checking bench for gamma_inverse_pwl: directed scenarios plus randomized streaming
// against a formula-level reference model (bypass scenario only with GAMMA_INV_BYPASS_EN).
module tb_gamma_inverse_pwl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inpvalid = 1'b0;
    logic [11:0] di [3];
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [12:0] wr_data = '0;
    logic        bypass = 1'b0;
    logic        outvalid;
    logic [11:0] dout0, dout1, dout2;
    logic [11:0] dq [3];

    int n_chk = 0;
    int n_bad = 0;

    gamma_inverse_pwl #(.DATA_W(12)) dut (
        .clk(clk), .rst(rst), .inpvalid(inpvalid),
        .din0(di[0]), .din1(di[1]), .din2(di[2]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef GAMMA_INV_BYPASS_EN
        .bypass(bypass),
`endif
        .outvalid(outvalid), .dout0(dout0), .dout1(dout1), .dout2(dout2)
    );

    assign dq[0] = dout0;
    assign dq[1] = dout1;
    assign dq[2] = dout2;

    always #5 clk = ~clk;

    // Reference model: table as integers, curve evaluated from the formula at sample time.
    int mbp [17];
    bit lv [2];
    int lr [2][3];
    bit e_vld;
    int e_d [3];

    function automatic int curve(input int x);
        int seg  = x / 256;
        int frac = x % 256;
        int d    = mbp[seg + 1] - mbp[seg];
        int y    = mbp[seg] + ((d * frac + 128) >>> 8);
        if (y < 0) y = 0;
        if (y > 4095) y = 4095;
        return y;
    endfunction

    always @(posedge clk or posedge rst) begin
        bit be;
        if (rst) begin
            for (int k = 0; k < 17; k++) mbp[k] <= 256 * k;
            lv[0] <= 1'b0;
            lv[1] <= 1'b0;
            e_vld <= 1'b0;
            for (int p = 0; p < 3; p++) e_d[p] <= 0;
        end else begin
`ifdef GAMMA_INV_BYPASS_EN
            be = bypass;
`else
            be = 1'b0;
`endif
            e_vld <= lv[1];
            if (lv[1]) for (int p = 0; p < 3; p++) e_d[p] <= lr[1][p];
            lv[1] <= lv[0];
            lr[1] <= lr[0];
            lv[0] <= inpvalid;
            for (int p = 0; p < 3; p++) lr[0][p] <= be ? int'(di[p]) : curve(int'(di[p]));
            if (wr_en && wr_addr <= 5'd16) mbp[wr_addr] <= int'(wr_data);
        end
    end

    task automatic cyc(input bit v, input int a, input int b, input int c,
                       input bit we = 1'b0, input int wa = 0, input int wd = 0,
                       input bit byp = 1'b0);
        inpvalid = v;
        di[0] = 12'(a);
        di[1] = 12'(b);
        di[2] = 12'(c);
        wr_en = we;
        wr_addr = 5'(wa);
        wr_data = 13'(wd);
        bypass = byp;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        n_chk++;
        if (outvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outvalid got=%0b exp=0", outvalid);
        end
        for (int p = 0; p < 3; p++) begin
            n_chk++;
            if (dq[p] !== 12'd0) begin
                n_bad++;
                $display("FAIL reset_dout%0d got=%0d exp=0", p, dq[p]);
            end
        end
        rst = 1'b0;
        cyc(0, 0, 0, 0);
    endtask

    task automatic test_identity();
        int vals [6] = '{0, 1, 255, 256, 2048, 4095};
        int q[$];
        for (int i = 0; i < 8; i++) begin
            if (i < 6) cyc(1, vals[i], vals[i], vals[i]);
            else cyc(0, 0, 0, 0);
            n_chk++;
            if (outvalid !== e_vld) begin
                n_bad++;
                $display("FAIL identity_outvalid got=%0b exp=%0b cyc=%0d", outvalid, e_vld, i);
            end
            for (int p = 0; p < 3; p++) begin
                n_chk++;
                if (dq[p] !== 12'(e_d[p])) begin
                    n_bad++;
                    $display("FAIL identity_dout%0d got=%0d exp=%0d cyc=%0d", p, dq[p], e_d[p], i);
                end
            end
            if (outvalid) q.push_back(int'(dout2));
        end
        n_chk++;
        if (q.size() != 6) begin
            n_bad++;
            $display("FAIL identity_count got=%0d exp=6", q.size());
        end
        for (int i = 0; i < 6; i++) begin
            n_chk++;
            if (i >= q.size() || q[i] != vals[i]) begin
                n_bad++;
                $display("FAIL identity_value idx=%0d got=%0d exp=%0d", i,
                         (i < q.size()) ? q[i] : -1, vals[i]);
            end
        end
    endtask

    task automatic load_scale();
        for (int k = 0; k < 17; k++) cyc(0, 0, 0, 0, 1'b1, k, (512 * k > 8191) ? 8191 : 512 * k);
    endtask

    task automatic test_scale();
        int vals [3] = '{1000, 4095, 2048};
        int expv [3] = '{2000, 4095, 4095};
        int q[$];
        load_scale();
        for (int i = 0; i < 5; i++) begin
            if (i < 3) cyc(1, vals[i], vals[i], vals[i]);
            else cyc(0, 0, 0, 0);
            n_chk++;
            if (outvalid !== e_vld) begin
                n_bad++;
                $display("FAIL scale_outvalid got=%0b exp=%0b cyc=%0d", outvalid, e_vld, i);
            end
            for (int p = 0; p < 3; p++) begin
                n_chk++;
                if (dq[p] !== 12'(e_d[p])) begin
                    n_bad++;
                    $display("FAIL scale_dout%0d got=%0d exp=%0d cyc=%0d", p, dq[p], e_d[p], i);
                end
            end
            if (outvalid) q.push_back(int'(dout0));
        end
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (i >= q.size() || q[i] != expv[i]) begin
                n_bad++;
                $display("FAIL scale_value idx=%0d got=%0d exp=%0d", i,
                         (i < q.size()) ? q[i] : -1, expv[i]);
            end
        end
    endtask

    task automatic test_reset_midstream();
        cyc(1, 500, 600, 700);
        cyc(1, 800, 900, 1000);
        cyc(1, 1100, 1200, 1300);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc(0, 0, 0, 0);
            n_chk++;
            if (outvalid !== 1'b0) begin
                n_bad++;
                $display("FAIL midrst_outvalid got=%0b exp=0 cyc=%0d", outvalid, i);
            end
            for (int p = 0; p < 3; p++) begin
                n_chk++;
                if (dq[p] !== 12'd0) begin
                    n_bad++;
                    $display("FAIL midrst_dout%0d got=%0d exp=0", p, dq[p]);
                end
            end
        end
        rst = 1'b0;
        cyc(0, 0, 0, 0);
        cyc(1, 1234, 1234, 1234);
        for (int i = 0; i < 2; i++) begin
            n_chk++;
            if (outvalid !== 1'b0) begin
                n_bad++;
                $display("FAIL midrst_early_valid got=%0b exp=0 cyc=%0d", outvalid, i);
            end
            cyc(0, 0, 0, 0);
        end
        n_chk++;
        if (outvalid !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_new_valid got=%0b exp=1", outvalid);
        end
        for (int p = 0; p < 3; p++) begin
            n_chk++;
            if (dq[p] !== 12'd1234) begin
                n_bad++;
                $display("FAIL midrst_new_dout%0d got=%0d exp=1234", p, dq[p]);
            end
        end
    endtask

    task automatic test_negative_slope();
        cyc(0, 0, 0, 0, 1'b1, 1, 0);
        cyc(0, 0, 0, 0, 1'b1, 5, 0);
        cyc(1, 384, 128, 1279);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        n_chk++;
        if (outvalid !== 1'b1 || dout0 !== 12'd256) begin
            n_bad++;
            $display("FAIL neg_seg1 got=%0d vld=%0b exp=256", dout0, outvalid);
        end
        n_chk++;
        if (dout1 !== 12'd0) begin
            n_bad++;
            $display("FAIL neg_flat got=%0d exp=0", dout1);
        end
        n_chk++;
        if (dout2 !== 12'd4) begin
            n_bad++;
            $display("FAIL neg_slope got=%0d exp=4", dout2);
        end
        cyc(0, 0, 0, 0, 1'b1, 1, 256);
        cyc(0, 0, 0, 0, 1'b1, 5, 1280);
    endtask

    task automatic test_coherency();
        int q[$];
        for (int i = 0; i < 10; i++) begin
            if (i < 8) cyc(1, 300, 300, 300, i == 3, 1, 356);
            else cyc(0, 0, 0, 0);
            n_chk++;
            if (outvalid !== e_vld || dout1 !== 12'(e_d[1])) begin
                n_bad++;
                $display("FAIL coher_model got=%0d/%0b exp=%0d/%0b cyc=%0d",
                         dout1, outvalid, e_d[1], e_vld, i);
            end
            if (outvalid) q.push_back(int'(dout0));
        end
        for (int i = 0; i < 8; i++) begin
            n_chk++;
            if (i >= q.size() || q[i] != ((i <= 3) ? 300 : 383)) begin
                n_bad++;
                $display("FAIL coher_value idx=%0d got=%0d exp=%0d", i,
                         (i < q.size()) ? q[i] : -1, (i <= 3) ? 300 : 383);
            end
        end
    endtask

`ifdef GAMMA_INV_BYPASS_EN
    task automatic test_bypass();
        int q[$];
        load_scale();
        for (int i = 0; i < 8; i++) begin
            if (i < 6) cyc(1, 1000, 1000, 1000, 1'b0, 0, 0, (i % 2) == 0);
            else cyc(0, 0, 0, 0);
            if (outvalid) q.push_back(int'(dout1));
        end
        n_chk++;
        if (q.size() != 6) begin
            n_bad++;
            $display("FAIL bypass_count got=%0d exp=6", q.size());
        end
        for (int i = 0; i < 6; i++) begin
            n_chk++;
            if (i >= q.size() || q[i] != (((i % 2) == 0) ? 1000 : 2000)) begin
                n_bad++;
                $display("FAIL bypass_value idx=%0d got=%0d exp=%0d", i,
                         (i < q.size()) ? q[i] : -1, ((i % 2) == 0) ? 1000 : 2000);
            end
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 9) < 7, $urandom_range(0, 4095), $urandom_range(0, 4095),
                $urandom_range(0, 4095), $urandom_range(0, 4) == 0, $urandom_range(0, 20),
                $urandom_range(0, 8191), $urandom_range(0, 1) == 1);
            n_chk++;
            if (outvalid !== e_vld) begin
                n_bad++;
                $display("FAIL rand_outvalid got=%0b exp=%0b cyc=%0d", outvalid, e_vld, i);
            end
            for (int p = 0; p < 3; p++) begin
                n_chk++;
                if (dq[p] !== 12'(e_d[p])) begin
                    n_bad++;
                    $display("FAIL rand_dout%0d got=%0d exp=%0d cyc=%0d", p, dq[p], e_d[p], i);
                end
            end
        end
    endtask

    initial begin
        for (int p = 0; p < 3; p++) di[p] = '0;
        @(negedge clk);
        test_reset();
        test_identity();
        test_scale();
        test_reset_midstream();
        test_negative_slope();
        test_coherency();
`ifdef GAMMA_INV_BYPASS_EN
        test_bypass();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
